// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative branch target buffer, dual lookup slots.
// Lookups are registered (1-cycle latency, no same-cycle forwarding). A single
// update port installs, overwrites or invalidates one entry. Full-set
// replacement uses a per-set round-robin pointer. A flush walks all sets.
module btb_assoc #(
  parameter int NWAY   = 4,
  parameter int NSET   = 64,
  parameter int TAGLEN = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc_0,
  input  logic [31:0] fetch_pc_1,
  output logic        hit_0,
  output logic        hit_1,
  output logic [31:0] target_pc_0,
  output logic [31:0] target_pc_1,
  output logic [2:0]  ins_type_0,
  output logic [2:0]  ins_type_1,
  input  logic        upd_valid,
  input  logic        upd_inv,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic [2:0]  upd_ins_type,
  input  logic        flush_req,
  output logic        busy
);

  localparam int SETW   = $clog2(NSET);
  localparam int WAYW   = $clog2(NWAY);
  localparam int HIGHW  = 30 - SETW;
  localparam int NSLICE = (HIGHW + TAGLEN - 1) / TAGLEN;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  // Set index taken directly above the word offset.
  function automatic logic [SETW-1:0] pc_set(input logic [31:0] pc);
    return pc[2+SETW-1:2];
  endfunction

  // Fold the bits above the index into TAGLEN bits by XOR of slices.
  function automatic logic [TAGLEN-1:0] pc_tag(input logic [31:0] pc);
    logic [NSLICE*TAGLEN-1:0] padded;
    logic [TAGLEN-1:0]        acc;
    padded            = '0;
    padded[HIGHW-1:0] = pc[31:2+SETW];
    acc               = '0;
    for (int i = 0; i < NSLICE; i++) begin
      acc = acc ^ TAGLEN'(padded >> (i * TAGLEN));
    end
    return acc;
  endfunction

  logic [NWAY-1:0]   valid_r [NSET];
  logic [WAYW-1:0]   rr_r    [NSET];
  logic [TAGLEN-1:0] tag_r   [NSET][NWAY];
  logic [31:0]       tgt_r   [NSET][NWAY];
  logic [2:0]        typ_r   [NSET][NWAY];

  state_t            state_r, state_nx_s;
  logic [SETW-1:0]   cnt_r, cnt_nx_s;

  logic [31:0]       lk_pc_s  [2];
  logic [SETW-1:0]   lk_set_s [2];
  logic              lk_hit_s [2];
  logic [WAYW-1:0]   lk_way_s [2];
  logic              lk_ok_s;

  logic [SETW-1:0]   up_set_s;
  logic [TAGLEN-1:0] up_tag_s;
  logic              up_hit_s, up_free_s, up_en_s;
  logic [WAYW-1:0]   up_hway_s, up_fway_s, wr_way_s;
  logic              wr_en_s, inv_en_s, rr_adv_s;

  // Tag match for both fetch slots; lowest-index matching way wins.
  always_comb begin
    lk_pc_s[0] = fetch_pc_0;
    lk_pc_s[1] = fetch_pc_1;
    lk_ok_s    = fetch_valid && (state_r == ST_IDLE);
    for (int s = 0; s < 2; s++) begin
      lk_set_s[s] = pc_set(lk_pc_s[s]);
      lk_hit_s[s] = 1'b0;
      lk_way_s[s] = '0;
      for (int w = NWAY - 1; w >= 0; w--) begin
        lk_hit_s[s] = lk_hit_s[s] |
                      (valid_r[lk_set_s[s]][WAYW'(w)] &&
                       (tag_r[lk_set_s[s]][WAYW'(w)] == pc_tag(lk_pc_s[s])));
        lk_way_s[s] = (valid_r[lk_set_s[s]][WAYW'(w)] &&
                       (tag_r[lk_set_s[s]][WAYW'(w)] == pc_tag(lk_pc_s[s])))
                      ? WAYW'(w) : lk_way_s[s];
      end
    end
  end

  // Update decode: hit way, first free way, and the resulting write/invalidate.
  always_comb begin
    up_set_s  = pc_set(upd_pc);
    up_tag_s  = pc_tag(upd_pc);
    up_hit_s  = 1'b0;
    up_hway_s = '0;
    up_free_s = 1'b0;
    up_fway_s = '0;
    for (int w = NWAY - 1; w >= 0; w--) begin
      up_hit_s  = up_hit_s | (valid_r[up_set_s][WAYW'(w)] &&
                              (tag_r[up_set_s][WAYW'(w)] == up_tag_s));
      up_hway_s = (valid_r[up_set_s][WAYW'(w)] &&
                   (tag_r[up_set_s][WAYW'(w)] == up_tag_s)) ? WAYW'(w) : up_hway_s;
      up_free_s = up_free_s | !valid_r[up_set_s][WAYW'(w)];
      up_fway_s = !valid_r[up_set_s][WAYW'(w)] ? WAYW'(w) : up_fway_s;
    end
    up_en_s  = upd_valid && (state_r == ST_IDLE);
    wr_en_s  = up_en_s && !upd_inv;
    inv_en_s = up_en_s && upd_inv && up_hit_s;
    rr_adv_s = wr_en_s && !up_hit_s && !up_free_s;
    if (up_hit_s) begin
      wr_way_s = up_hway_s;
    end else if (up_free_s) begin
      wr_way_s = up_fway_s;
    end else begin
      wr_way_s = rr_r[up_set_s];
    end
  end

  // Flush sequencer next-state: one set cleared per CLEAR cycle.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (flush_req) begin
          state_nx_s = ST_CLEAR;
          cnt_nx_s   = '0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cnt_nx_s = cnt_r + SETW'(1);
        if (cnt_r == SETW'(NSET - 1)) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_CLEAR;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // Flush sequencer state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Valid bits and round-robin pointers: sweep in CLEAR, update in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NSET; s++) begin
        valid_r[SETW'(s)] <= '0;
        rr_r[SETW'(s)]    <= '0;
      end
    end else if (state_r == ST_CLEAR) begin
      valid_r[cnt_r] <= '0;
      rr_r[cnt_r]    <= '0;
    end else begin
      if (wr_en_s) begin
        valid_r[up_set_s][wr_way_s] <= 1'b1;
      end else if (inv_en_s) begin
        valid_r[up_set_s][up_hway_s] <= 1'b0;
      end
      if (rr_adv_s) begin
        rr_r[up_set_s] <= rr_r[up_set_s] + WAYW'(1);
      end
    end
  end

  // Entry payload arrays; not reset, qualified by valid.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tag_r[up_set_s][wr_way_s] <= up_tag_s;
      tgt_r[up_set_s][wr_way_s] <= upd_target;
      typ_r[up_set_s][wr_way_s] <= upd_ins_type;
    end
  end

  // Registered lookup results and busy flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_0       <= 1'b0;
      hit_1       <= 1'b0;
      target_pc_0 <= 32'h0;
      target_pc_1 <= 32'h0;
      ins_type_0  <= 3'd0;
      ins_type_1  <= 3'd0;
      busy        <= 1'b0;
    end else begin
      hit_0       <= lk_ok_s && lk_hit_s[0];
      hit_1       <= lk_ok_s && lk_hit_s[1];
      target_pc_0 <= (lk_ok_s && lk_hit_s[0]) ? tgt_r[lk_set_s[0]][lk_way_s[0]] : 32'h0;
      target_pc_1 <= (lk_ok_s && lk_hit_s[1]) ? tgt_r[lk_set_s[1]][lk_way_s[1]] : 32'h0;
      ins_type_0  <= (lk_ok_s && lk_hit_s[0]) ? typ_r[lk_set_s[0]][lk_way_s[0]] : 3'd0;
      ins_type_1  <= (lk_ok_s && lk_hit_s[1]) ? typ_r[lk_set_s[1]][lk_way_s[1]] : 3'd0;
      busy        <= (state_nx_s == ST_CLEAR);
    end
  end

endmodule
